axi_llc_way_req_arb: RTL and testbench

- Shares the single data-storage way request port between NumReq cache units: R channel, W channel, evict and refill.
- Arbitration is round-robin, with the grant locked for the length of a requester's burst.
- Read requests (`we==0`) are tracked in an in-order outstanding FIFO. Data-way responses are routed back to the requester that issued them.
- Sits between the LLC units and the data way storage.

---
 rtl/axi_llc_way_req_arb.sv | 204 ++++++++++++++++++++
 tb/tb_axi_llc_way_req_arb.sv | 274 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/axi_llc_way_req_arb.sv
// -----------------------------------------------------------------------------
// axi_llc_way_req_arb
//
// Shares the single data-way request port between NumReq LLC units
// (0 = R channel, 1 = W channel, 2 = evict, 3 = refill). Arbitration is
// round-robin. Once a requester has a beat accepted that is not the last of
// its burst, the grant is locked to that requester until its last beat is
// accepted. Read requests are recorded in an in-order FIFO so that each data-way
// response is steered back to the requester that issued the read.
//
// The request payload is a flat vector. Bit WeBit is the write-enable. Writes
// produce no response.
//
// Ports
//   clk_i            clock, rising edge
//   rst_ni           synchronous active-low reset
//   req_i            request payload per requester
//   req_last_i       beat is the last of its burst, per requester
//   req_valid_i      request valid, per requester
//   req_ready_o      request accepted, per requester (only granted bit can be 1)
//   way_inp_o        payload forwarded to the data ways
//   way_inp_valid_o  request valid to the data ways
//   way_inp_ready_i  data ways accept the request
//   way_out_i        read response from the data ways
//   way_out_valid_i  response valid
//   way_out_ready_o  response accepted
//   resp_o           response payload, broadcast to every requester
//   resp_valid_o     response valid, one-hot on the FIFO head requester
//   resp_ready_i     requester accepts the response
// -----------------------------------------------------------------------------
module axi_llc_way_req_arb #(
  parameter int unsigned NumReq         = 4,
  parameter int unsigned MaxOutstanding = 4,
  parameter int unsigned InpW           = 16,
  parameter int unsigned OupW           = 16,
  parameter int unsigned WeBit          = 0
) (
  input  logic                           clk_i,
  input  logic                           rst_ni,
  input  logic [NumReq-1:0][InpW-1:0]    req_i,
  input  logic [NumReq-1:0]              req_last_i,
  input  logic [NumReq-1:0]              req_valid_i,
  output logic [NumReq-1:0]              req_ready_o,
  output logic [InpW-1:0]                way_inp_o,
  output logic                           way_inp_valid_o,
  input  logic                           way_inp_ready_i,
  input  logic [OupW-1:0]                way_out_i,
  input  logic                           way_out_valid_i,
  output logic                           way_out_ready_o,
  output logic [NumReq-1:0][OupW-1:0]    resp_o,
  output logic [NumReq-1:0]              resp_valid_o,
  input  logic [NumReq-1:0]              resp_ready_i
);

  localparam int unsigned IdxW = (NumReq > 1) ? $clog2(NumReq) : 1;
  localparam int unsigned PtrW = (MaxOutstanding > 1) ? $clog2(MaxOutstanding) : 1;
  localparam int unsigned CntW = $clog2(MaxOutstanding + 1);

  if (NumReq < 2) begin : g_numreq_chk
    $error("axi_llc_way_req_arb: NumReq must be at least 2");
  end

  function automatic logic [IdxW-1:0] idx_inc(input logic [IdxW-1:0] v);
    return (v == IdxW'(NumReq - 1)) ? '0 : v + 1'b1;
  endfunction

  function automatic logic [PtrW-1:0] ptr_inc(input logic [PtrW-1:0] v);
    return (v == PtrW'(MaxOutstanding - 1)) ? '0 : v + 1'b1;
  endfunction

  // Control state
  logic                  lock_q, lock_d;
  logic [IdxW-1:0]       lock_idx_q, lock_idx_d;
  logic [IdxW-1:0]       rr_ptr_q, rr_ptr_d;
  logic [PtrW-1:0]       wr_ptr_q, wr_ptr_d;
  logic [PtrW-1:0]       rd_ptr_q, rd_ptr_d;
  logic [CntW-1:0]       fifo_cnt_q, fifo_cnt_d;
  // FIFO storage holds data only, so it is not reset
  logic [IdxW-1:0]       fifo_mem_q [MaxOutstanding];

  logic                  fifo_full, fifo_empty;
  logic [NumReq-1:0]     elig;
  logic [IdxW-1:0]       sel_idx, gnt_idx, fifo_head;
  logic                  hs, push, pop;

  assign fifo_full  = (fifo_cnt_q == CntW'(MaxOutstanding));
  assign fifo_empty = (fifo_cnt_q == '0);
  assign fifo_head  = fifo_mem_q[rd_ptr_q];

  // Reads need a free FIFO slot for their response; writes never do
  for (genvar i = 0; i < NumReq; i++) begin : g_elig
    assign elig[i]   = req_valid_i[i] & (req_i[i][WeBit] | ~fifo_full);
    assign resp_o[i] = way_out_i;
  end

  // Round-robin search starting at rr_ptr_q
  always_comb begin
    logic            found;
    logic [IdxW-1:0] cand;
    found   = 1'b0;
    sel_idx = rr_ptr_q;
    cand    = rr_ptr_q;
    for (int k = 0; k < NumReq; k++) begin
      if (!found && elig[cand]) begin
        found   = 1'b1;
        sel_idx = cand;
      end
      cand = idx_inc(cand);
    end
  end

  // A locked burst stalls everyone else, even if its owner is not eligible
  assign gnt_idx         = lock_q ? lock_idx_q : sel_idx;
  assign way_inp_o       = req_i[gnt_idx];
  assign way_inp_valid_o = rst_ni & elig[gnt_idx];
  assign hs              = way_inp_valid_o & way_inp_ready_i;
  assign push            = hs & ~way_inp_o[WeBit];

  always_comb begin
    req_ready_o          = '0;
    req_ready_o[gnt_idx] = hs;
  end

  always_comb begin
    resp_valid_o            = '0;
    resp_valid_o[fifo_head] = rst_ni & way_out_valid_i & ~fifo_empty;
  end

  assign way_out_ready_o = rst_ni & ~fifo_empty & resp_ready_i[fifo_head];
  assign pop             = way_out_valid_i & way_out_ready_o;

  always_comb begin
    lock_d     = lock_q;
    lock_idx_d = lock_idx_q;
    rr_ptr_d   = rr_ptr_q;
    if (hs) begin
      if (req_last_i[gnt_idx]) begin
        lock_d   = 1'b0;
        rr_ptr_d = idx_inc(gnt_idx);
      end else begin
        lock_d     = 1'b1;
        lock_idx_d = gnt_idx;
      end
    end
    wr_ptr_d   = push ? ptr_inc(wr_ptr_q) : wr_ptr_q;
    rd_ptr_d   = pop  ? ptr_inc(rd_ptr_q) : rd_ptr_q;
    fifo_cnt_d = fifo_cnt_q;
    if (push && !pop) begin
      fifo_cnt_d = fifo_cnt_q + 1'b1;
    end else if (!push && pop) begin
      fifo_cnt_d = fifo_cnt_q - 1'b1;
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      lock_q     <= 1'b0;
      lock_idx_q <= '0;
      rr_ptr_q   <= '0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      fifo_cnt_q <= '0;
    end else begin
      lock_q     <= lock_d;
      lock_idx_q <= lock_idx_d;
      rr_ptr_q   <= rr_ptr_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      fifo_cnt_q <= fifo_cnt_d;
    end
  end

  always_ff @(posedge clk_i) begin
    if (push) begin
      fifo_mem_q[wr_ptr_q] <= gnt_idx;
    end
  end

`ifndef SYNTHESIS
  logic [NumReq-1:0]           stall_q;
  logic [NumReq-1:0][InpW-1:0] req_prev_q;

  always_ff @(posedge clk_i) begin
    stall_q    <= rst_ni ? (req_valid_i & ~req_ready_o) : '0;
    req_prev_q <= req_i;
    if (rst_ni) begin
      for (int i = 0; i < NumReq; i++) begin
        if (stall_q[i] && req_valid_i[i]) begin
          assert (req_i[i] == req_prev_q[i])
            else $error("request payload changed while waiting for ready");
        end
      end
      assert ($onehot0(resp_valid_o)) else $error("resp_valid_o not one-hot0");
      if (push) begin
        assert (!fifo_full) else $error("outstanding FIFO push while full");
      end
      if (way_out_valid_i) begin
        assert (!fifo_empty) else $error("way response with no outstanding read");
      end
    end
  end
`endif

endmodule

// File: tb/tb_axi_llc_way_req_arb.sv
module tb_axi_llc_way_req_arb;
  localparam int N  = 4;
  localparam int MO = 4;
  localparam int IW = 16;
  localparam int OW = 16;

  logic                  clk = 1'b0;
  logic                  rst_ni;
  logic [N-1:0][IW-1:0]  req_i;
  logic [N-1:0]          req_last_i;
  logic [N-1:0]          req_valid_i;
  logic [N-1:0]          req_ready_o;
  logic [IW-1:0]         way_inp_o;
  logic                  way_inp_valid_o;
  logic                  way_inp_ready_i;
  logic [OW-1:0]         way_out_i;
  logic                  way_out_valid_i;
  logic                  way_out_ready_o;
  logic [N-1:0][OW-1:0]  resp_o;
  logic [N-1:0]          resp_valid_o;
  logic [N-1:0]          resp_ready_i;

  always #5 clk = ~clk;

  axi_llc_way_req_arb #(
    .NumReq(N), .MaxOutstanding(MO), .InpW(IW), .OupW(OW), .WeBit(0)
  ) dut (
    .clk_i(clk), .rst_ni(rst_ni),
    .req_i(req_i), .req_last_i(req_last_i), .req_valid_i(req_valid_i),
    .req_ready_o(req_ready_o),
    .way_inp_o(way_inp_o), .way_inp_valid_o(way_inp_valid_o),
    .way_inp_ready_i(way_inp_ready_i),
    .way_out_i(way_out_i), .way_out_valid_i(way_out_valid_i),
    .way_out_ready_o(way_out_ready_o),
    .resp_o(resp_o), .resp_valid_o(resp_valid_o), .resp_ready_i(resp_ready_i)
  );

  int n_vec = 0;
  int n_err = 0;

  // Model state: lock, lock owner, priority pointer, outstanding read owners
  bit mlock;
  int midx;
  int mptr;
  int mq[$];
  // Observed grant order and response targets, for literal checks
  int glog[$];
  int rlog[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic int oh_idx(input logic [N-1:0] v);
    for (int i = 0; i < N; i++) if (v[i]) return i;
    return 15;
  endfunction

  // Each log entry becomes one hex digit (index + 1), oldest first
  function automatic int enc_g();
    int r = 0;
    foreach (glog[i]) r = r * 16 + glog[i] + 1;
    return r;
  endfunction

  function automatic int enc_r();
    int r = 0;
    foreach (rlog[i]) r = r * 16 + rlog[i] + 1;
    return r;
  endfunction

  always @(negedge clk) begin : compare
    logic [N-1:0] el;
    logic [N-1:0] exp_rdy;
    logic [N-1:0] exp_rv;
    logic [1:0]   gi;
    logic [1:0]   hi;
    logic         exp_v;
    logic         exp_wor;
    bit           full;
    int           g;
    if (!rst_ni) begin
      chk("rst_inp_valid", 32'(way_inp_valid_o), 32'd0);
      chk("rst_req_ready", 32'(req_ready_o), 32'd0);
      chk("rst_resp_valid", 32'(resp_valid_o), 32'd0);
      chk("rst_out_ready", 32'(way_out_ready_o), 32'd0);
      mlock = 0;
      mptr  = 0;
      mq.delete();
    end else begin
      full = (mq.size() >= MO);
      for (int i = 0; i < N; i++) el[i] = req_valid_i[i] && (req_i[i][0] || !full);
      g = -1;
      if (mlock) g = midx;
      else begin
        for (int k = 0; k < N; k++) begin
          int c;
          c = (mptr + k) % N;
          if (g < 0 && el[2'(c)]) g = c;
        end
      end
      gi      = 2'(g < 0 ? 0 : g);
      exp_v   = (g >= 0) && el[gi];
      exp_rdy = '0;
      if (exp_v && way_inp_ready_i) exp_rdy[gi] = 1'b1;
      chk("inp_valid", 32'(way_inp_valid_o), 32'(exp_v));
      chk("req_ready", 32'(req_ready_o), 32'(exp_rdy));
      if (exp_v) chk("inp_payload", 32'(way_inp_o), 32'(req_i[gi]));
      exp_rv  = '0;
      exp_wor = 1'b0;
      hi      = 2'd0;
      if (mq.size() > 0) begin
        hi      = 2'(mq[0]);
        exp_wor = resp_ready_i[hi];
        if (way_out_valid_i) exp_rv[hi] = 1'b1;
      end
      chk("resp_valid", 32'(resp_valid_o), 32'(exp_rv));
      chk("out_ready", 32'(way_out_ready_o), 32'(exp_wor));
      if (way_out_valid_i) begin
        for (int i = 0; i < N; i++) chk("resp_payload", 32'(resp_o[i]), 32'(way_out_i));
      end
      if (way_inp_valid_o && way_inp_ready_i) glog.push_back(oh_idx(req_ready_o));
      if (way_out_valid_i && way_out_ready_o) rlog.push_back(oh_idx(resp_valid_o));
      if (way_out_valid_i && exp_wor) void'(mq.pop_front());
      if (exp_v && way_inp_ready_i) begin
        if (!req_i[gi][0]) mq.push_back(g);
        if (req_last_i[gi]) begin
          mlock = 0;
          mptr  = (g + 1) % N;
        end else begin
          mlock = 1;
          midx  = g;
        end
      end
    end
  end

  task automatic step(input int n = 1);
    repeat (n) @(posedge clk);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    rst_ni = 0; req_i = '0; req_last_i = '1; req_valid_i = '0;
    way_inp_ready_i = 1'b1; way_out_i = '0; way_out_valid_i = 1'b0; resp_ready_i = '1;
    step(2);
    rst_ni = 1;
    chk("reset_rr", 32'(dut.rr_ptr_q), 32'd0);
    chk("reset_lock", 32'(dut.lock_q), 32'd0);
    chk("reset_cnt", 32'(dut.fifo_cnt_q), 32'd0);

    // Two single-beat reads from 0 and 2, then their responses
    req_i[0] = 16'h1000; req_i[2] = 16'h2000; req_valid_i = 4'b0101;
    step();
    chk("t1_rr_a", 32'(dut.rr_ptr_q), 32'd1);
    req_valid_i[0] = 1'b0;
    step();
    chk("t1_rr_b", 32'(dut.rr_ptr_q), 32'd3);
    chk("t1_cnt", 32'(dut.fifo_cnt_q), 32'd2);
    req_valid_i = '0;
    chk("t1_grants", 32'(enc_g()), 32'h13);
    way_out_valid_i = 1'b1; way_out_i = 16'hAAAA;
    step();
    way_out_i = 16'hBBBB;
    step();
    way_out_valid_i = 1'b0;
    chk("t1_resp_targets", 32'(enc_r()), 32'h13);
    chk("t1_cnt_empty", 32'(dut.fifo_cnt_q), 32'd0);

    // 4-beat write burst from 1 locks out a continuously valid 3
    glog.delete();
    req_i[0] = 16'h0001; req_valid_i = 4'b0001;
    step();
    req_valid_i = 4'b1010;
    req_i[1] = 16'h1101; req_last_i[1] = 1'b0; req_i[3] = 16'h3301;
    step();
    chk("t2_lock", 32'(dut.lock_q), 32'd1);
    req_i[1] = 16'h1201; step();
    req_i[1] = 16'h1301; step();
    req_i[1] = 16'h1401; req_last_i[1] = 1'b1; step();
    req_valid_i[1] = 1'b0; step();
    req_valid_i = '0;
    chk("t2_grants", 32'(enc_g()), 32'h122224);
    chk("t2_rr", 32'(dut.rr_ptr_q), 32'd0);

    // Locked 4-beat read from 0 with a 3-cycle valid gap
    glog.delete();
    req_i[0] = 16'h5000; req_last_i[0] = 1'b0; req_valid_i = 4'b1001;
    step();
    req_i[0] = 16'h5100; step();
    req_valid_i[0] = 1'b0;
    step(3);
    chk("t3_gap_grants", 32'(enc_g()), 32'h11);
    chk("t3_gap_lock", 32'(dut.lock_q), 32'd1);
    req_valid_i[0] = 1'b1; req_i[0] = 16'h5200; step();
    req_i[0] = 16'h5300; req_last_i[0] = 1'b1; step();
    req_valid_i[0] = 1'b0; step();
    req_valid_i = '0;
    chk("t3_grants", 32'(enc_g()), 32'h11114);
    chk("t3_cnt", 32'(dut.fifo_cnt_q), 32'd4);
    way_out_valid_i = 1'b1; way_out_i = 16'hC0DE;
    step(4);
    way_out_valid_i = 1'b0;
    chk("t3_drain", 32'(dut.fifo_cnt_q), 32'd0);

    // FIFO full: 5th read stalls, write passes, read goes after a pop
    glog.delete();
    req_i[0] = 16'h6000; req_valid_i = 4'b0001;
    step();
    req_i[0] = 16'h6100; step();
    req_i[0] = 16'h6200; step();
    req_i[0] = 16'h6300; step();
    req_i[0] = 16'h6400; req_i[1] = 16'h1701; req_valid_i = 4'b0011;
    step();
    req_valid_i[1] = 1'b0;
    step();
    chk("t4_cnt_full", 32'(dut.fifo_cnt_q), 32'd4);
    chk("t4_grants_a", 32'(enc_g()), 32'h11112);
    way_out_valid_i = 1'b1; way_out_i = 16'h0F0F;
    step();
    way_out_valid_i = 1'b0;
    chk("t4_no_bypass", 32'(enc_g()), 32'h11112);
    step();
    req_valid_i = '0;
    chk("t4_grants_b", 32'(enc_g()), 32'h111121);
    chk("t4_cnt_after", 32'(dut.fifo_cnt_q), 32'd4);
    way_out_valid_i = 1'b1;
    step(4);
    way_out_valid_i = 1'b0;

    // Response back-pressure from requester 2
    glog.delete(); rlog.delete();
    req_i[2] = 16'h2200; req_valid_i = 4'b0100;
    step();
    req_valid_i = '0;
    way_out_valid_i = 1'b1; way_out_i = 16'h2222; resp_ready_i = 4'b1011;
    step(2);
    chk("t5_held_cnt", 32'(dut.fifo_cnt_q), 32'd1);
    chk("t5_held_resp", 32'(enc_r()), 32'h0);
    resp_ready_i = '1;
    step();
    way_out_valid_i = 1'b0;
    chk("t5_resp", 32'(enc_r()), 32'h3);
    chk("t5_cnt", 32'(dut.fifo_cnt_q), 32'd0);

    // Reset in the middle of a locked read burst with 2 reads outstanding
    req_i[0] = 16'h7000; req_last_i[0] = 1'b0; req_valid_i = 4'b0001;
    step();
    req_i[0] = 16'h7100; step();
    chk("t6_lock_pre", 32'(dut.lock_q), 32'd1);
    chk("t6_cnt_pre", 32'(dut.fifo_cnt_q), 32'd2);
    rst_ni = 0; req_valid_i = '0; req_last_i = '1;
    step();
    rst_ni = 1;
    chk("t6_lock", 32'(dut.lock_q), 32'd0);
    chk("t6_rr", 32'(dut.rr_ptr_q), 32'd0);
    chk("t6_cnt", 32'(dut.fifo_cnt_q), 32'd0);
    chk("t6_outs", 32'({way_inp_valid_o, req_ready_o, resp_valid_o, way_out_ready_o}), 32'd0);
    step(2);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
